seg7_scan_capture: RTL and testbench

//  Listening end of the multiplexed 7-segment bus (AN/SEG) driven by the calculator display scanner.

---
 rtl/seg7_scan_capture.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_capture.sv
// rtl/seg7_scan_capture.sv - listener for a multiplexed 7-segment AN/SEG bus, publishes decoded 4-digit frames
//
// Follows the anode scan on the bus. Each digit's segment pattern must settle before it is
// decoded to hex. A coherent 4-digit frame is published once every digit has been captured.
//
// Parameters:
//   STABLE_CYC   cycles {an,seg} must stay unchanged inside one anode window before capture (1..255)
//   TIMEOUT_CYC  cycles without a capture of a digit before its dig_valid bit drops (>= STABLE_CYC)
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   an[3:0]    anode selects, active-low, an[i]=0 selects digit i (digit 3 leftmost)
//   seg[7:0]   segments, active-low, seg[0..6]=a..g, seg[7]=dp
//   digits     decoded hex frame, digits[4i+3:4i] = digit i
//   dp         decimal point per digit (1 = lit)
//   blank      1 = digit captured with all of a..g off
//   dig_valid  1 = digit captured within the last TIMEOUT_CYC cycles
//   frame_stb  one-cycle pulse when digits/dp/blank are updated
//   err        one-cycle pulse on an illegal a..g pattern or on entry into a multi-anode condition
//   err_cnt    saturating error-pulse counter, present only when SEG7_CAPTURE_ERRCNT_EN is defined
//
// Optional feature macro: SEG7_CAPTURE_ERRCNT_EN

module seg7_scan_capture #(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  blank,
  output logic [3:0]  dig_valid,
  output logic        frame_stb,
  output logic        err
`ifdef SEG7_CAPTURE_ERRCNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  localparam int unsigned TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
  localparam logic [7:0]    SMAX = 8'(STABLE_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } state_e;

  // Synchroniser plus one extra stage holding last cycle's synchronised value.
  // The anode stages come out of reset as "no anode active" so that the
  // reset value itself never looks like a multi-anode condition.
  logic [3:0] an_s1_q, an_s2_q, an_p_q;
  logic [7:0] seg_s1_q, seg_s2_q, seg_p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_s1_q  <= 4'hF;
      an_s2_q  <= 4'hF;
      an_p_q   <= 4'hF;
      seg_s1_q <= 8'hFF;
      seg_s2_q <= 8'hFF;
      seg_p_q  <= 8'hFF;
    end else begin
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
      an_p_q   <= an_s2_q;
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
      seg_p_q  <= seg_s2_q;
    end
  end

  // Anode classification on the synchronised bus
  logic [2:0] n_act;
  logic [1:0] idx;
  logic       win;
  logic       multi;
  logic       changed;

  always_comb begin
    n_act = 3'd0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!an_s2_q[k]) begin
        n_act = n_act + 3'd1;
        idx   = 2'(k);
      end
    end
  end

  assign win     = (n_act == 3'd1);
  assign multi   = (n_act >= 3'd2);
  assign changed = ({an_s2_q, seg_s2_q} != {an_p_q, seg_p_q});

  // Segment decode, a..g made active-high with g as MSB
  logic [6:0] pat;
  logic       pat_ok;
  logic       pat_blank;
  logic [3:0] pat_nib;

  assign pat = ~seg_s2_q[6:0];

  always_comb begin
    pat_ok    = 1'b1;
    pat_blank = 1'b0;
    pat_nib   = 4'h0;
    case (pat)
      7'h3F: pat_nib = 4'h0;
      7'h06: pat_nib = 4'h1;
      7'h5B: pat_nib = 4'h2;
      7'h4F: pat_nib = 4'h3;
      7'h66: pat_nib = 4'h4;
      7'h6D: pat_nib = 4'h5;
      7'h7D: pat_nib = 4'h6;
      7'h07: pat_nib = 4'h7;
      7'h7F: pat_nib = 4'h8;
      7'h6F: pat_nib = 4'h9;
      7'h77: pat_nib = 4'hA;
      7'h7C: pat_nib = 4'hB;
      7'h39: pat_nib = 4'hC;
      7'h5E: pat_nib = 4'hD;
      7'h79: pat_nib = 4'hE;
      7'h71: pat_nib = 4'hF;
      7'h00: pat_blank = 1'b1;
      default: pat_ok = 1'b0;
    endcase
  end

  // Capture FSM next state. The stable counter counts cycles the current
  // {an,seg} has been seen, starting at 1 on the first cycle of a window.
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       attempt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    attempt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win) begin
          state_d = S_SETTLE;
          cnt_d   = 8'd1;
        end
      end
      S_SETTLE: begin
        if (!changed) begin
          cnt_d = cnt_q + 8'd1;
        end else if (win) begin
          cnt_d = 8'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (changed) begin
          if (win) begin
            state_d = S_SETTLE;
            cnt_d   = 8'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // One capture attempt per window; HOLD then waits for the bus to move on
    if (state_d == S_SETTLE && cnt_d == SMAX) begin
      attempt = 1'b1;
      state_d = S_HOLD;
    end
  end

  // Staging, commit and timeout next state
  logic [15:0]   stage_dig_q, stage_dig_d;
  logic [3:0]    stage_dp_q, stage_dp_d;
  logic [3:0]    stage_blank_q, stage_blank_d;
  logic [3:0]    seen_q, seen_d;
  logic [3:0]    cap_vec;
  logic [3:0]    seen_all;
  logic          cap_ok;
  logic          cap_bad;
  logic          commit_now;
  logic          commit_pend_q;
  logic          multi_q;
  logic          err_d;
  logic [TW-1:0] tcnt_q [4];
  logic [TW-1:0] tcnt_d [4];
  logic [3:0]    dig_valid_q, dig_valid_d;
  logic [15:0]   digits_q;
  logic [3:0]    dp_q;
  logic [3:0]    blank_q;
  logic          frame_stb_q;
  logic          err_q;

  assign cap_ok     = attempt & pat_ok;
  assign cap_bad    = attempt & ~pat_ok;
  assign cap_vec    = cap_ok ? (4'b0001 << idx) : 4'b0000;
  assign seen_all   = seen_q | cap_vec;
  assign commit_now = cap_ok && (seen_all == 4'hF);
  assign seen_d     = commit_now ? 4'h0 : seen_all;
  assign err_d      = (multi & ~multi_q) | cap_bad;

  always_comb begin
    stage_dig_d   = stage_dig_q;
    stage_dp_d    = stage_dp_q;
    stage_blank_d = stage_blank_q;
    if (cap_ok) begin
      stage_dig_d[{idx, 2'b00} +: 4] = pat_nib;
      stage_dp_d[idx]                = ~seg_s2_q[7];
      stage_blank_d[idx]             = pat_blank;
    end
  end

  // Per-digit age counters; a capture on the same cycle as expiry keeps the digit valid
  always_comb begin
    dig_valid_d = dig_valid_q;
    for (int k = 0; k < 4; k++) begin
      tcnt_d[k] = tcnt_q[k];
      if (cap_vec[k]) begin
        tcnt_d[k] = '0;
      end else if (tcnt_q[k] != TMAX) begin
        tcnt_d[k] = tcnt_q[k] + TW'(1);
      end
      if (commit_pend_q) begin
        dig_valid_d[k] = 1'b1;
      end else if (tcnt_q[k] == TMAX && !cap_vec[k]) begin
        dig_valid_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      stage_dig_q   <= 16'h0;
      stage_dp_q    <= 4'h0;
      stage_blank_q <= 4'h0;
      seen_q        <= 4'h0;
      commit_pend_q <= 1'b0;
      multi_q       <= 1'b0;
      dig_valid_q   <= 4'h0;
      digits_q      <= 16'h0;
      dp_q          <= 4'h0;
      blank_q       <= 4'h0;
      frame_stb_q   <= 1'b0;
      err_q         <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        tcnt_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stage_dig_q   <= stage_dig_d;
      stage_dp_q    <= stage_dp_d;
      stage_blank_q <= stage_blank_d;
      seen_q        <= seen_d;
      commit_pend_q <= commit_now;
      multi_q       <= multi;
      dig_valid_q   <= dig_valid_d;
      frame_stb_q   <= commit_pend_q;
      err_q         <= err_d;
      // The frame is copied one cycle after the 4th capture lands in staging,
      // so every output field changes together on the frame_stb cycle.
      if (commit_pend_q) begin
        digits_q <= stage_dig_q;
        dp_q     <= stage_dp_q;
        blank_q  <= stage_blank_q;
      end
      for (int k = 0; k < 4; k++) begin
        tcnt_q[k] <= tcnt_d[k];
      end
    end
  end

  assign digits    = digits_q;
  assign dp        = dp_q;
  assign blank     = blank_q;
  assign dig_valid = dig_valid_q;
  assign frame_stb = frame_stb_q;
  assign err       = err_q;

`ifdef SEG7_CAPTURE_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else if (err_d && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  // Error counter not built; err pulses are the only error indication.
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb/tb_seg7_scan_capture.sv - self-checking bench for seg7_scan_capture
module tb_seg7_scan_capture;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 500;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  dig_valid;
  logic        frame_stb;
  logic        err;
`ifdef SEG7_CAPTURE_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  seg7_scan_capture #(
    .STABLE_CYC (STABLE),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .an       (an),
    .seg      (seg),
    .digits   (digits),
    .dp       (dp),
    .blank    (blank),
    .dig_valid(dig_valid),
    .frame_stb(frame_stb),
    .err      (err)
`ifdef SEG7_CAPTURE_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_seen = 0;
  int stb_seen = 0;
  int base_err;
  int base_stb;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_seen <= err_seen + 1;
      if (frame_stb) stb_seen <= stb_seen + 1;
    end
  end

  // Reference model: digit glyph table and the frame the bus should produce
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0]  m_stage [4];
  logic [3:0]  m_sdp, m_sblank, m_seen, m_dp, m_blank, m_vflag;
  logic [15:0] m_dig;
  int          m_frames, m_err;
  bit          m_prev_multi;
  int          m_last [4];

  function automatic int lookup(input logic [6:0] p);
    if (p == 7'h00) return 16;
    for (int i = 0; i < 16; i++) if (tbl[i] == p) return i;
    return -1;
  endfunction

  function automatic int nzero(input logic [3:0] a);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) n++;
    return n;
  endfunction

  function automatic logic [7:0] enc(input logic [6:0] p, input bit dp_lit);
    return {~dp_lit, ~p};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_stage[i] = 4'h0;
      m_last[i]  = 0;
    end
    m_sdp = 0; m_sblank = 0; m_seen = 0; m_dp = 0; m_blank = 0; m_vflag = 0;
    m_dig = 0; m_frames = 0; m_err = 0; m_prev_multi = 0;
    base_err = err_seen;
    base_stb = stb_seen;
  endtask

  // A held bus value lasting n cycles: one window, captured when long enough
  task automatic model_apply(input logic [3:0] a, input logic [7:0] s, input int n);
    int na;
    int d;
    int r;
    na = nzero(a);
    if (na >= 2 && !m_prev_multi) m_err++;
    m_prev_multi = (na >= 2);
    if (na == 1 && n >= STABLE) begin
      d = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) d = i;
      r = lookup(~s[6:0]);
      if (r < 0) begin
        m_err++;
      end else begin
        m_stage[d]  = (r == 16) ? 4'h0 : 4'(r);
        m_sblank[d] = (r == 16);
        m_sdp[d]    = ~s[7];
        m_seen[d]   = 1'b1;
        m_last[d]   = cyc + 2 + STABLE;
        if (m_seen == 4'hF) begin
          m_dig    = {m_stage[3], m_stage[2], m_stage[1], m_stage[0]};
          m_dp     = m_sdp;
          m_blank  = m_sblank;
          m_vflag  = 4'hF;
          m_seen   = 4'h0;
          m_frames++;
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [7:0] s, input int n);
    model_apply(a, s, n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    an  = 4'hF;
    seg = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    an  = 4'b0000;
    seg = 8'hFF;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({digits, dp, blank, dig_valid, frame_stb, err} !== 30'b0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0", {digits, dp, blank, dig_valid, frame_stb, err});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    base_err = err_seen;
    base_stb = stb_seen;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (err_seen - base_err !== 1) begin
      errors++;
      $display("FAIL reset_multi_err got %0d expected 1", err_seen - base_err);
    end
    checks++;
    if (stb_seen - base_stb !== 0) begin
      errors++;
      $display("FAIL reset_no_frame got %0d expected 0", stb_seen - base_stb);
    end
    an = 4'hF;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_scan_1234();
    int lat;
    do_reset();
    step(4'b1110, enc(7'h06, 0), 20);
    step(4'b1101, enc(7'h5B, 0), 20);
    step(4'b1011, enc(7'h4F, 0), 20);
    model_apply(4'b0111, enc(7'h66, 0), 20);
    an  = 4'b0111;
    seg = enc(7'h66, 0);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (frame_stb && lat < 0) lat = c;
      @(posedge clk);
      #1;
    end
    step(4'hF, 8'hFF, 5);
    checks++;
    if (lat !== 2 + STABLE + 1) begin
      errors++;
      $display("FAIL scan_latency got %0d expected %0d", lat, 2 + STABLE + 1);
    end
    checks++;
    if (stb_seen - base_stb !== 1) begin
      errors++;
      $display("FAIL scan_frame_count got %0d expected 1", stb_seen - base_stb);
    end
    checks++;
    if (digits !== 16'h4321 || digits !== m_dig) begin
      errors++;
      $display("FAIL scan_digits got %h expected 4321 (model %h)", digits, m_dig);
    end
    checks++;
    if ({dig_valid, blank, dp} !== {4'hF, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL scan_flags got valid %b blank %b dp %b expected 1111 0000 0000", dig_valid, blank, dp);
    end
    checks++;
    if (err_seen - base_err !== 0) begin
      errors++;
      $display("FAIL scan_no_err got %0d expected 0", err_seen - base_err);
    end
  endtask

  task automatic test_short_window();
    do_reset();
    step(4'b1101, enc(7'h5B, 0), 20);
    step(4'b1011, enc(7'h4F, 0), 20);
    step(4'b0111, enc(7'h66, 0), 20);
    step(4'b1110, enc(7'h3F, 0), STABLE - 1);
    step(4'b1110, enc(7'h06, 0), 2);
    step(4'hF, 8'hFF, 10);
    checks++;
    if (stb_seen - base_stb !== m_frames || m_frames != 0) begin
      errors++;
      $display("FAIL short_no_commit got %0d expected 0", stb_seen - base_stb);
    end
    step(4'b1110, enc(7'h3F, 0), 20);
    step(4'hF, 8'hFF, 5);
    checks++;
    if (stb_seen - base_stb !== m_frames) begin
      errors++;
      $display("FAIL short_full_commit got %0d expected %0d", stb_seen - base_stb, m_frames);
    end
    checks++;
    if (digits !== m_dig) begin
      errors++;
      $display("FAIL short_digits got %h expected %h", digits, m_dig);
    end
  endtask

  task automatic test_blank_dp();
    do_reset();
    step(4'b1110, enc(7'h06, 0), 20);
    step(4'b1101, enc(7'h5B, 0), 20);
    step(4'b1011, 8'h7F, 20);
    step(4'b0111, enc(7'h66, 0), 20);
    step(4'hF, 8'hFF, 5);
    checks++;
    if (blank !== 4'b0100 || blank !== m_blank) begin
      errors++;
      $display("FAIL blank_bits got %b expected 0100", blank);
    end
    checks++;
    if (dp !== 4'b0100 || dp !== m_dp) begin
      errors++;
      $display("FAIL dp_bits got %b expected 0100", dp);
    end
    checks++;
    if (digits !== m_dig || digits[11:8] !== 4'h0) begin
      errors++;
      $display("FAIL blank_digits got %h expected %h", digits, m_dig);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    step(4'b1110, enc(7'h06, 0), 20);
    step(4'b1011, enc(7'h4F, 0), 20);
    step(4'b0111, enc(7'h66, 0), 20);
    step(4'b1101, enc(7'h01, 0), 20);
    step(4'hF, 8'hFF, 10);
    checks++;
    if (err_seen - base_err !== m_err || m_err != 1) begin
      errors++;
      $display("FAIL illegal_err got %0d expected 1", err_seen - base_err);
    end
    checks++;
    if (stb_seen - base_stb !== 0) begin
      errors++;
      $display("FAIL illegal_no_commit got %0d expected 0", stb_seen - base_stb);
    end
    step(4'b1101, enc(7'h5B, 0), 20);
    step(4'hF, 8'hFF, 5);
    checks++;
    if (stb_seen - base_stb !== 1 || digits !== m_dig) begin
      errors++;
      $display("FAIL illegal_recover got stb %0d digits %h expected 1 %h", stb_seen - base_stb, digits, m_dig);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(4'b1110, enc(7'h06, 0), 20);
    step(4'b1101, enc(7'h5B, 0), 20);
    step(4'b1011, enc(7'h4F, 0), 20);
    step(4'b0111, enc(7'h66, 0), 20);
    for (int r = 0; r < (TIMEOUT + 100) / 60; r++) begin
      step(4'b1110, enc(7'h06, 0), 20);
      step(4'b1101, enc(7'h5B, 0), 20);
      step(4'b1011, enc(7'h4F, 0), 20);
    end
    checks++;
    if (dig_valid !== 4'b0111) begin
      errors++;
      $display("FAIL timeout_valid got %b expected 0111", dig_valid);
    end
    checks++;
    if (digits !== 16'h4321 || digits !== m_dig) begin
      errors++;
      $display("FAIL timeout_digits got %h expected %h", digits, m_dig);
    end
  endtask

  task automatic test_random();
    int kind;
    int d;
    int age;
    logic [6:0] p;
    logic [3:0] a;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7) begin
        d = $urandom_range(0, 3);
        a = 4'hF;
        a[d] = 1'b0;
        p = ($urandom_range(0, 16) == 16) ? 7'h00 : tbl[$urandom_range(0, 15)];
        step(a, enc(p, 1'($urandom_range(0, 1))), $urandom_range(2, 10));
      end else if (kind == 7) begin
        d = $urandom_range(0, 3);
        a = 4'hF;
        a[d] = 1'b0;
        p = 7'h01;
        for (int t = 0; t < 100; t++) begin
          p = 7'($urandom_range(1, 127));
          if (lookup(p) < 0) break;
        end
        if (lookup(p) >= 0) p = 7'h01;
        step(a, enc(p, 0), $urandom_range(2, 8));
      end else begin
        a = 4'b0000;
        for (int t = 0; t < 100; t++) begin
          a = 4'($urandom_range(0, 15));
          if (nzero(a) >= 2) break;
        end
        if (nzero(a) < 2) a = 4'b0000;
        step(a, 8'($urandom_range(0, 255)), $urandom_range(1, 4));
      end
      step(4'hF, 8'hFF, $urandom_range(1, 3));
    end
    step(4'hF, 8'hFF, 10);
    checks++;
    if (stb_seen - base_stb !== m_frames) begin
      errors++;
      $display("FAIL rand_frames got %0d expected %0d", stb_seen - base_stb, m_frames);
    end
    checks++;
    if (err_seen - base_err !== m_err) begin
      errors++;
      $display("FAIL rand_errs got %0d expected %0d", err_seen - base_err, m_err);
    end
    checks++;
    if ({digits, dp, blank} !== {m_dig, m_dp, m_blank}) begin
      errors++;
      $display("FAIL rand_frame got %h/%b/%b expected %h/%b/%b", digits, dp, blank, m_dig, m_dp, m_blank);
    end
    for (int k = 0; k < 4; k++) begin
      age = cyc - m_last[k];
      if (m_vflag[k] && age < TIMEOUT - 5) begin
        checks++;
        if (dig_valid[k] !== 1'b1) begin
          errors++;
          $display("FAIL rand_valid%0d got %b expected 1 (age %0d)", k, dig_valid[k], age);
        end
      end else if (!m_vflag[k] || age > TIMEOUT + 5) begin
        checks++;
        if (dig_valid[k] !== 1'b0) begin
          errors++;
          $display("FAIL rand_valid%0d got %b expected 0 (age %0d)", k, dig_valid[k], age);
        end
      end
    end
`ifdef SEG7_CAPTURE_ERRCNT_EN
    checks++;
    if (int'(err_cnt) !== ((m_err > 255) ? 255 : m_err)) begin
      errors++;
      $display("FAIL rand_err_cnt got %0d expected %0d", err_cnt, (m_err > 255) ? 255 : m_err);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    an  = 4'hF;
    seg = 8'hFF;
    test_reset();
    test_scan_1234();
    test_short_window();
    test_blank_dp();
    test_illegal();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
